// File: rtl/ntt_bypass_pkg.sv
// Shared types and helpers for the NTT CT-butterfly bypass stand-in.
package ntt_bypass_pkg;

    typedef enum logic [1:0] {
        BYP_PASS = 2'd0,
        BYP_REV2 = 2'd1,
        BYP_TAG  = 2'd2,
        BYP_RSVD = 2'd3
    } bypass_mode_e;

    // Bit-reverse the low 'width' bits of idx.
    function automatic int rev_idx(input int idx, input int width);
        int r;
        r = 0;
        for (int b = 0; b < width; b++) begin
            r = r | (((idx >> b) & 1) << (width - 1 - b));
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_bypass_delay_line.sv
// Per-stage-enabled shift register; RST_MODE 0 = no reset, 1 = reset to 0, 2 = reset to all-ones.
module ntt_bypass_delay_line #(
    parameter int WIDTH    = 1,
    parameter int DEPTH    = 1,
    parameter int RST_MODE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DEPTH-1:0]             en_i,
    input  logic [WIDTH-1:0]             d_i,
    output logic [DEPTH-1:0][WIDTH-1:0]  stg_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stg_q, stg_d;

    // A stage only moves when its incoming slot is marked valid.
    always_comb begin
        stg_d = stg_q;
        if (en_i[0]) stg_d[0] = d_i;
        for (int k = 1; k < DEPTH; k++) begin
            if (en_i[k]) stg_d[k] = stg_q[k-1];
        end
    end

    generate
        if (RST_MODE == 0) begin : g_nrst
            logic unused_rst;
            assign unused_rst = rst;
            always_ff @(posedge clk) stg_q <= stg_d;
        end else begin : g_rst
            localparam logic [WIDTH-1:0] RST_VAL = (RST_MODE == 2) ? '1 : '0;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) stg_q <= {DEPTH{RST_VAL}};
                else     stg_q <= stg_d;
            end
        end
    endgenerate

    assign stg_o = stg_q;

endmodule

// File: rtl/ntt_radix_ct_bypass_pipe.sv
// Radix CT butterfly stand-in: lane permute/tag transform carried through a LATENCY-deep pipe.
// Define NTT_CT_BYPASS_GATE_EN to load data/side stages only on valid and zero xf_a when idle.
module ntt_radix_ct_bypass_pipe
    import ntt_bypass_pkg::*;
#(
    parameter int            R          = 8,
    parameter int            OP_W       = 32,
    parameter logic [OP_W:0] MOD_M      = ((OP_W+1)'(1) << OP_W) - ((OP_W+1)'(1) << (OP_W/2)) + (OP_W+1)'(1),
    parameter int            OMG_SEL_NB = 2,
    parameter int            SIDE_W     = 0,
    parameter int            RST_SIDE   = 0,
    parameter int            LATENCY    = 1,
    localparam int           OMG_SEL_W  = (OMG_SEL_NB == 1) ? 1 : $clog2(OMG_SEL_NB),
    localparam int           CNT_W      = $clog2(LATENCY + 1),
    localparam int           SW         = (SIDE_W > 0) ? SIDE_W : 1
) (
    input  logic                             clk,
    input  logic                             a_rst,
    input  logic [R*OP_W-1:0]                xt_a,
    input  logic [(R-1)*OP_W-1:0]            phi_a,
    input  logic [OMG_SEL_NB*(R/2)*OP_W-1:0] omg_a,
    input  logic [OMG_SEL_W-1:0]             omg_sel,
    input  logic [1:0]                       mode,
    input  logic                             in_avail,
    input  logic [SW-1:0]                    in_side,
    output logic [R*OP_W-1:0]                xf_a,
    output logic                             out_avail,
    output logic [SW-1:0]                    out_side,
    output logic [CNT_W-1:0]                 inflight,
    output logic                             err
);

    localparam int LOG_R = $clog2(R);
    localparam logic [OMG_SEL_W:0] NB_C = (OMG_SEL_W+1)'(OMG_SEL_NB);
    localparam int SIDE_RST = ((RST_SIDE & 1) != 0) ? 1 : (((RST_SIDE & 2) != 0) ? 2 : 0);

    logic [R-1:0][OP_W-1:0]            lane_in, xfm;
    logic [OP_W:0]                     sum;
    logic [LATENCY-1:0][0:0]           vld_stg;
    logic [LATENCY-1:0][R*OP_W-1:0]    data_stg;
    logic [LATENCY-1:0][SW-1:0]        side_stg;
    logic [LATENCY-1:0]                data_en;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic                              err_q, err_d;
    logic                              unused_roots;

    assign unused_roots = ^{phi_a, omg_a};
    assign lane_in      = xt_a;

    // Tag mode relies on inputs < MOD_M, so one conditional subtract suffices.
    always_comb begin
        xfm = lane_in;
        sum = '0;
        for (int i = 0; i < R; i++) begin
            unique case (bypass_mode_e'(mode))
                BYP_REV2: xfm[i] = lane_in[LOG_R'(rev_idx(i, LOG_R))];
                BYP_TAG: begin
                    sum = {1'b0, lane_in[i]} + (OP_W+1)'(i);
                    if (sum >= MOD_M) sum = sum - MOD_M;
                    xfm[i] = sum[OP_W-1:0];
                end
                default: xfm[i] = lane_in[i];
            endcase
        end
    end

    ntt_bypass_delay_line #(.WIDTH(1), .DEPTH(LATENCY), .RST_MODE(1)) u_vld (
        .clk(clk), .rst(a_rst), .en_i({LATENCY{1'b1}}), .d_i(in_avail), .stg_o(vld_stg)
    );

`ifdef NTT_CT_BYPASS_GATE_EN
    always_comb begin
        data_en[0] = in_avail;
        for (int k = 1; k < LATENCY; k++) data_en[k] = vld_stg[k-1][0];
    end
    assign xf_a = out_avail ? data_stg[LATENCY-1] : '0;
`else
    logic unused_vld;
    assign unused_vld = ^vld_stg;
    assign data_en    = '1;
    assign xf_a       = data_stg[LATENCY-1];
`endif

    ntt_bypass_delay_line #(.WIDTH(R*OP_W), .DEPTH(LATENCY), .RST_MODE(1)) u_data (
        .clk(clk), .rst(a_rst), .en_i(data_en), .d_i(xfm), .stg_o(data_stg)
    );

    ntt_bypass_delay_line #(.WIDTH(SW), .DEPTH(LATENCY), .RST_MODE(SIDE_RST)) u_side (
        .clk(clk), .rst(a_rst), .en_i(data_en), .d_i(in_side), .stg_o(side_stg)
    );

    assign out_avail = vld_stg[LATENCY-1][0];
    assign out_side  = side_stg[LATENCY-1];

    always_comb begin
        cnt_d = cnt_q;
        if (in_avail && !out_avail)      cnt_d = cnt_q + CNT_W'(1);
        else if (!in_avail && out_avail) cnt_d = cnt_q - CNT_W'(1);
        err_d = err_q | (in_avail & (({1'b0, omg_sel} >= NB_C) | (mode == BYP_RSVD)));
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign inflight = cnt_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ntt_radix_ct_bypass_pipe.sv
// Directed bench for ntt_radix_ct_bypass_pipe (R=8, OP_W=32, LATENCY=4, 3 omega sets, 8-bit side).
module tb_ntt_radix_ct_bypass_pipe;

    localparam int R   = 8;
    localparam int OP_W = 32;
    localparam int NB  = 3;
    localparam int SW  = 8;
    localparam int LAT = 4;

    logic                     clk = 1'b0;
    logic                     a_rst;
    logic [R*OP_W-1:0]        xt_a, xf_a;
    logic [(R-1)*OP_W-1:0]    phi_a;
    logic [NB*(R/2)*OP_W-1:0] omg_a;
    logic [1:0]               omg_sel, mode;
    logic                     in_avail, out_avail, err;
    logic [SW-1:0]            in_side, out_side;
    logic [2:0]               inflight;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ntt_radix_ct_bypass_pipe #(
        .R(R), .OP_W(OP_W), .OMG_SEL_NB(NB), .SIDE_W(SW), .RST_SIDE(1), .LATENCY(LAT)
    ) dut (
        .clk(clk), .a_rst(a_rst), .xt_a(xt_a), .phi_a(phi_a), .omg_a(omg_a),
        .omg_sel(omg_sel), .mode(mode), .in_avail(in_avail), .in_side(in_side),
        .xf_a(xf_a), .out_avail(out_avail), .out_side(out_side),
        .inflight(inflight), .err(err)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_avail = 1'b0;
        mode     = 2'd0;
        omg_sel  = 2'd0;
        xt_a     = {8{32'hDEAD_BEEF}};
    endtask

    // Drive one sample, then step until its output slot (LAT cycles after in_avail).
    task automatic send1(input logic [1:0] m, input logic [255:0] d, input logic [7:0] s);
        mode     = m;
        xt_a     = d;
        in_side  = s;
        in_avail = 1'b1;
        cyc();
        idle();
        repeat (LAT - 1) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [255:0] d, e;
        logic [255:0] sd [20];
        logic [255:0] se [20];
        int           e1 [8];
        int           rv [8];
        int           npulse, exp_if, c1, left;

        e1 = '{10, 14, 12, 16, 11, 15, 13, 17};
        rv = '{0, 4, 2, 6, 1, 5, 3, 7};

        a_rst = 1'b1; xt_a = '0; phi_a = '0; omg_a = '0;
        omg_sel = 2'd0; mode = 2'd0; in_avail = 1'b0; in_side = '0;
        repeat (2) cyc();
        chk("rst_avail", 256'(out_avail), 256'(0));
        chk("rst_inflight", 256'(inflight), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_xf", xf_a, 256'(0));
        chk("rst_side", 256'(out_side), 256'(0));
        a_rst = 1'b0;
        cyc();

        // Mode 0 single sample: latency and inflight profile.
        for (int i = 0; i < R; i++) e[i*32 +: 32] = 32'h100 + 32'(i);
        xt_a = e; in_side = 8'hA5; mode = 2'd0; in_avail = 1'b1;
        cyc();
        idle();
        for (int k = 1; k <= LAT; k++) begin
            chk("m0_inflight", 256'(inflight), 256'(1));
            chk("m0_avail", 256'(out_avail), 256'(k == LAT));
            if (k == LAT) begin
                chk("m0_xf", xf_a, e);
                chk("m0_side", 256'(out_side), 256'(8'hA5));
            end
            cyc();
        end
        chk("m0_inflight_end", 256'(inflight), 256'(0));
        chk("m0_avail_end", 256'(out_avail), 256'(0));

        // Mode 1: bit-reversed lane routing.
        for (int i = 0; i < R; i++) begin
            d[i*32 +: 32] = 32'(10 + i);
            e[i*32 +: 32] = 32'(e1[i]);
        end
        send1(2'd1, d, 8'h11);
        chk("m1_avail", 256'(out_avail), 256'(1));
        chk("m1_xf", xf_a, e);
        cyc();

        // Mode 2: modular lane tag, roots randomised to show they are ignored.
        phi_a = {7{$urandom}};
        omg_a = {12{$urandom}};
        omg_sel = 2'd2;
        d = {32'hFFFE_FFFE, 32'h60, 32'hFFFF_0000, 32'h40, 32'h30, 32'h20, 32'h5, 32'hFFFF_0000};
        e = {32'h4,         32'h66, 32'h4,         32'h44, 32'h33, 32'h22, 32'h6, 32'hFFFF_0000};
        mode = 2'd2; xt_a = d; in_side = 8'h22; in_avail = 1'b1;
        cyc();
        idle();
        repeat (LAT - 1) cyc();
        chk("m2_avail", 256'(out_avail), 256'(1));
        chk("m2_xf", xf_a, e);
        chk("m2_err", 256'(err), 256'(0));
        cyc();

        // Back-to-back stream, modes 0,1,2 repeating.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < R; i++) sd[t][i*32 +: 32] = 32'((t << 8) | i);
            for (int i = 0; i < R; i++) begin
                case (t % 3)
                    0: se[t][i*32 +: 32] = 32'((t << 8) | i);
                    1: se[t][i*32 +: 32] = 32'((t << 8) | rv[i]);
                    default: se[t][i*32 +: 32] = 32'((t << 8) | i) + 32'(i);
                endcase
            end
        end
        npulse = 0;
        for (int c = 0; c < 20 + LAT; c++) begin
            if (c < 20) begin
                xt_a = sd[c]; mode = 2'(c % 3); in_side = 8'(c); in_avail = 1'b1;
            end else begin
                idle();
            end
            cyc();
            c1 = c + 1;
            left = (c1 - LAT < 0) ? 0 : ((c1 - LAT > 20) ? 20 : c1 - LAT);
            exp_if = ((c1 < 20) ? c1 : 20) - left;
            chk("st_inflight", 256'(inflight), 256'(exp_if));
            chk("st_avail", 256'(out_avail), 256'((c1 - LAT >= 0) && (c1 - LAT < 20)));
            if (out_avail) begin
                npulse++;
                if ((c1 - LAT >= 0) && (c1 - LAT < 20)) begin
                    chk("st_xf", xf_a, se[c1 - LAT]);
                    chk("st_side", 256'(out_side), 256'(8'(c1 - LAT)));
                end
            end
        end
        chk("st_pulses", 256'(npulse), 256'(20));

        // Error flag: only with in_avail, then sticky.
        omg_sel = 2'd3; in_avail = 1'b0;
        cyc();
        chk("err_sel_idle", 256'(err), 256'(0));
        omg_sel = 2'd0; mode = 2'd3;
        cyc();
        chk("err_mode_idle", 256'(err), 256'(0));
        mode = 2'd0; omg_sel = 2'd3; in_avail = 1'b1;
        cyc();
        idle();
        chk("err_sel_set", 256'(err), 256'(1));
        repeat (LAT + 1) cyc();
        chk("err_sticky", 256'(err), 256'(1));
        a_rst = 1'b1;
        #1;
        chk("err_rst", 256'(err), 256'(0));
        cyc();
        a_rst = 1'b0;
        cyc();

        // Mode 3: data passes unchanged, err set.
        for (int i = 0; i < R; i++) d[i*32 +: 32] = 32'h300 + 32'(i);
        send1(2'd3, d, 8'h33);
        chk("m3_avail", 256'(out_avail), 256'(1));
        chk("m3_xf", xf_a, d);
        chk("m3_err", 256'(err), 256'(1));
        cyc();
        a_rst = 1'b1;
        cyc();
        a_rst = 1'b0;
        cyc();

        // Reset with three samples in flight.
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < R; i++) xt_a[i*32 +: 32] = 32'h700 + 32'((s << 4) | i);
            in_side = 8'h70 + 8'(s); mode = 2'd0; in_avail = 1'b1;
            cyc();
        end
        idle();
        chk("mr_inflight", 256'(inflight), 256'(3));
        chk("mr_avail_pre", 256'(out_avail), 256'(0));
        a_rst = 1'b1;
        #1;
        chk("mr_avail", 256'(out_avail), 256'(0));
        chk("mr_inflight0", 256'(inflight), 256'(0));
        chk("mr_xf", xf_a, 256'(0));
        chk("mr_side", 256'(out_side), 256'(0));
        cyc();
        a_rst = 1'b0;
        for (int k = 0; k < LAT + 2; k++) begin
            cyc();
            chk("mr_no_avail", 256'(out_avail), 256'(0));
`ifdef NTT_CT_BYPASS_GATE_EN
            chk("mr_idle_xf", xf_a, 256'(0));
`endif
        end
        chk("mr_inflight_end", 256'(inflight), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
